// File: rtl/button_press_classifier.sv
// Push-button front end: synchronise, debounce, then classify each debounced press as short or long.
// The short/long flags stay set until the CPU read path pulses clear.
module button_press_classifier #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 40_000_000,
    parameter int CNT_W           = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             btn_raw,
    input  logic             clear,
    output logic             pressed,
    output logic             short_press,
    output logic             long_press,
    output logic [CNT_W-1:0] hold_count
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } state_t;

    logic [1:0]       sync_reg;
    logic             btn_s;
    logic [CNT_W-1:0] db_cnt_reg, db_cnt_next;
    logic             pressed_reg, pressed_next;
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] hold_reg, hold_next;
    logic             short_reg, short_next;
    logic             long_reg, long_next;
    logic             set_short, set_long;

    assign btn_s = sync_reg[1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_reg    <= '0;
            db_cnt_reg  <= '0;
            pressed_reg <= 1'b0;
            state_reg   <= IDLE;
            hold_reg    <= '0;
            short_reg   <= 1'b0;
            long_reg    <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[0], btn_raw};
            db_cnt_reg  <= db_cnt_next;
            pressed_reg <= pressed_next;
            state_reg   <= state_next;
            hold_reg    <= hold_next;
            short_reg   <= short_next;
            long_reg    <= long_next;
        end
    end

    // Any cycle where the synchronised input agrees with the accepted level restarts the count.
    always_comb begin
        db_cnt_next  = '0;
        pressed_next = pressed_reg;
        if (btn_s != pressed_reg) begin
            if (db_cnt_reg == DB_LAST) begin
                pressed_next = ~pressed_reg;
            end else begin
                db_cnt_next = db_cnt_reg + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        set_short  = 1'b0;
        set_long   = 1'b0;
        case (state_reg)
            IDLE: begin
                // hold_count keeps the previous press length until a new press starts.
                if (pressed_reg) begin
                    state_next = HELD;
                    hold_next  = CNT_W'(1);
                end
            end
            HELD: begin
                if (!pressed_reg) begin
                    set_short  = 1'b1;
                    state_next = IDLE;
                end else begin
                    hold_next = hold_reg + 1'b1;
                    if (hold_reg == LONG_LAST) begin
                        set_long   = 1'b1;
                        state_next = LONG;
                    end
                end
            end
            LONG: begin
                if (!pressed_reg) begin
                    state_next = IDLE;
                end else if (hold_reg != CNT_MAX) begin
                    hold_next = hold_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A set in the same cycle as clear wins so a press is never lost to a racing read.
    always_comb begin
        short_next = set_short | (short_reg & ~clear);
        long_next  = set_long  | (long_reg  & ~clear);
    end

    assign pressed     = pressed_reg;
    assign short_press = short_reg;
    assign long_press  = long_reg;
    assign hold_count  = hold_reg;

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed bench for button_press_classifier with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_button_press_classifier;

    localparam int CNT_W = 32;

    logic             clock;
    logic             reset;
    logic             btn_raw;
    logic             clear;
    logic             pressed;
    logic             short_press;
    logic             long_press;
    logic [CNT_W-1:0] hold_count;

    int checks;
    int errors;

    button_press_classifier #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (20),
        .CNT_W          (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .clear      (clear),
        .pressed    (pressed),
        .short_press(short_press),
        .long_press (long_press),
        .hold_count (hold_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s did not match", tag);
        end
        $display("check %-16s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic check_outputs(input string tag, input logic p, input logic s,
                                 input logic l, input logic [31:0] hc);
        check({tag, ".pressed"}, 32'(pressed), 32'(p));
        check({tag, ".short"},   32'(short_press), 32'(s));
        check({tag, ".long"},    32'(long_press), 32'(l));
        check({tag, ".hold"},    hold_count, hc);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b0;
        btn_raw = 1'b0;
        clear   = 1'b0;
        #1;
        tick(3);
        check_outputs("rst", 1'b0, 1'b0, 1'b0, 32'd0);
        reset = 1'b1;
        tick(2);
        check_outputs("idle", 1'b0, 1'b0, 1'b0, 32'd0);

        // Bounce 1/0/1, then 10 clocks high and 10 low. E0 = first sample of the final 1.
        btn_raw = 1'b1; tick(1);
        btn_raw = 1'b0; tick(1);
        btn_raw = 1'b1;
        tick(5);
        check("bounce.pre", 32'(pressed), 32'd0);
        tick(1);
        check("bounce.rise", 32'(pressed), 32'd1);
        tick(4);
        btn_raw = 1'b0;                  // last high sample was E9
        tick(5);
        check("bounce.hold", 32'(pressed), 32'd1);
        tick(1);                         // pressed falls at E15, HELD saw 10 clocks
        check_outputs("bounce.fall", 1'b0, 1'b0, 1'b0, 32'd10);
        tick(1);
        check_outputs("short", 1'b0, 1'b1, 1'b0, 32'd10);
        tick(3);

        // Clear pulse drops the flag one edge later and leaves hold_count alone.
        clear = 1'b1; tick(1); clear = 1'b0;
        check_outputs("clear", 1'b0, 1'b0, 1'b0, 32'd10);

        // Short press of 8 samples; clear asserted on the edge that sets short_press.
        btn_raw = 1'b1; tick(8);
        btn_raw = 1'b0; tick(6);         // pressed fell at E13
        check("race.pre", 32'(short_press), 32'd0);
        clear = 1'b1; tick(1); clear = 1'b0;
        check_outputs("race.set", 1'b0, 1'b1, 1'b0, 32'd8);
        tick(1);
        check("race.hold", 32'(short_press), 32'd1);
        clear = 1'b1; tick(1); clear = 1'b0;
        check("race.clr", 32'(short_press), 32'd0);

        // Long hold: 40 clocks high. pressed rises E5, long_press at E25.
        btn_raw = 1'b1;
        tick(6);
        check_outputs("long.rise", 1'b1, 1'b0, 1'b0, 32'd8);
        tick(1);
        check("long.hc1", hold_count, 32'd1);
        tick(18);
        check_outputs("long.pre", 1'b1, 1'b0, 1'b0, 32'd19);
        tick(1);
        check_outputs("long.set", 1'b1, 1'b0, 1'b1, 32'd20);
        tick(14);
        check("long.release", hold_count, 32'd34);
        btn_raw = 1'b0;
        tick(5);
        check("long.stillp", 32'(pressed), 32'd1);
        tick(1);
        check_outputs("long.fall", 1'b0, 1'b0, 1'b1, 32'd40);
        tick(4);
        check_outputs("long.idle", 1'b0, 1'b0, 1'b1, 32'd40);

        // A short press before clear: both flags end up set.
        btn_raw = 1'b1; tick(8);
        btn_raw = 1'b0; tick(8);
        check_outputs("both", 1'b0, 1'b1, 1'b1, 32'd8);
        clear = 1'b1; tick(1); clear = 1'b0;
        check_outputs("both.clr", 1'b0, 1'b0, 1'b0, 32'd8);

        // Glitches of 3 clocks never reach the debounce threshold.
        for (int g = 0; g < 5; g++) begin
            btn_raw = 1'b1;
            for (int k = 0; k < 3; k++) begin
                tick(1);
                check("glitch.hi", 32'(pressed), 32'd0);
            end
            btn_raw = 1'b0;
            for (int k = 0; k < 3; k++) begin
                tick(1);
                check("glitch.lo", 32'(pressed), 32'd0);
            end
        end
        tick(6);
        check_outputs("glitch.end", 1'b0, 1'b0, 1'b0, 32'd8);

        // Reset at hold_count=10 while the button stays down.
        btn_raw = 1'b1;
        tick(16);
        check_outputs("mid.pre", 1'b1, 1'b0, 1'b0, 32'd10);
        reset = 1'b0;
        #1;
        check_outputs("mid.async", 1'b0, 1'b0, 1'b0, 32'd0);
        tick(2);
        check_outputs("mid.inrst", 1'b0, 1'b0, 1'b0, 32'd0);
        reset = 1'b1;
        tick(5);
        check("mid.pre_rise", 32'(pressed), 32'd0);
        tick(1);
        check("mid.rise", 32'(pressed), 32'd1);
        tick(1);
        check("mid.hc1", hold_count, 32'd1);
        btn_raw = 1'b0;
        tick(12);
        check_outputs("mid.short", 1'b0, 1'b1, 1'b0, 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timed out");
    end

endmodule
